// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpu_pkg
// Purpose : Shared GPU types and constants, plus the per-channel brightness
//           scaler used by the scanline output pipeline.
// Contents: SCREEN_W / SCREEN_H, rgb_t ({R,G,B}), coord_t, scale_chan(),
//           scale_rgb()
// Revision: 1.0 - initial release
// ============================================================================
package gpu_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [23:0] rgb_t;
  typedef logic [9:0]  coord_t;

  // Brightness 255 is treated as exact unity; otherwise (c * b) >> 8, which
  // always fits in 8 bits because both operands are 8 bits.
  function automatic logic [7:0] scale_chan(input logic [7:0] c,
                                            input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * {8'd0, b};
    return (b == 8'hFF) ? c : prod[15:8];
  endfunction

  function automatic rgb_t scale_rgb(input rgb_t p, input logic [7:0] b);
    return {scale_chan(p[23:16], b), scale_chan(p[15:8], b),
            scale_chan(p[7:0], b)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// Module  : line_ram
// Purpose : Simple dual-port memory holding two scanline banks of WIDTH
//           24-bit pixels. Addresses are {bank, column}; the column must be
//           below WIDTH (the caller guarantees this).
// Ports   : clk                      - clock
//           wr_en, wr_addr, wr_data  - synchronous write port
//           rd_en, rd_addr, rd_data  - read port with registered output
//                                      (rd_data holds when rd_en is low)
// Revision: 1.0 - initial release
// ============================================================================
module line_ram #(
  parameter int WIDTH = 640,
  parameter int XW    = 10
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [XW:0]   wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          rd_en,
  input  logic [XW:0]   rd_addr,
  output logic [23:0]   rd_data
);

  logic [23:0] mem [2][WIDTH];
  logic [23:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[XW]][wr_addr[XW-1:0]] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr[XW]][rd_addr[XW-1:0]];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/scanline_buffer.sv
`default_nettype none
// ============================================================================
// Module  : scanline_buffer
// Purpose : Double-buffered scanline store between the pixel renderer and the
//           VGA timing controller. The renderer fills the back bank while the
//           front bank streams out with brightness scaling. Banks swap on
//           every line_start.
// Ports   : clk, rst (async, active low)
//           line_start, vlookahead, pix_en, x      - from the vga controller
//           wr_valid/wr_ready, wr_x, wr_rgb          - renderer write port
//           bg_rgb                                   - clear colour
//           brightness                               - 255 = unity
//           R, G, B                                  - scaled pixel output
//           wr_err                                   - sticky bad-column flag
// Config  : SCANLINE_CLEAR_EN - when defined, the back bank is filled with
//           bg_rgb during the 640 clks after every swap (wr_ready low).
// Revision: 1.0 - initial release
// ============================================================================
module scanline_buffer
  import gpu_pkg::*;
#(
  parameter int WIDTH = SCREEN_W,
  parameter int XW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_start,
  input  logic          vlookahead,
  input  logic          pix_en,
  input  logic [XW-1:0] x,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [XW-1:0] wr_x,
  input  logic [23:0]   wr_rgb,
  input  logic [23:0]   bg_rgb,
  input  logic [7:0]    brightness,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          wr_err
);

  localparam logic [XW-1:0] C_W_X    = XW'(WIDTH);
  localparam logic [XW-1:0] C_LAST_X = XW'(WIDTH - 1);

  logic          front_q, front_d;
  logic          wr_err_q, wr_err_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_black_q, rd_black_d;
  logic [23:0]   rgb_q, rgb_d;

  logic          idle;
  logic          wr_acc;
  logic          ram_we;
  logic [XW:0]   ram_wa;
  logic [23:0]   ram_wd;
  logic [XW:0]   ram_ra;
  logic [23:0]   ram_rd;

`ifdef SCANLINE_CLEAR_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [XW-1:0] clr_x_q, clr_x_d;

  assign idle = (state_q == ST_IDLE);
`else
  logic unused_bg;
  assign unused_bg = ^bg_rgb;
  assign idle      = 1'b1;
`endif

  // Gated by rst so the port drops the instant reset is asserted.
  assign wr_ready = rst && vlookahead && idle;
  assign wr_acc   = wr_valid && wr_ready;

  // Write side: bank select, renderer writes and (optionally) the clear FSM.
  always_comb begin
    front_d  = front_q ^ line_start;
    wr_err_d = wr_err_q;
    ram_we   = 1'b0;
    ram_wa   = {~front_q, wr_x};
    ram_wd   = wr_rgb;

    if (wr_acc) begin
      if (wr_x < C_W_X) begin
        ram_we = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end

`ifdef SCANLINE_CLEAR_EN
    state_d = state_q;
    clr_x_d = clr_x_q;
    // On a line_start cycle ~front_q is the bank about to go on display, so
    // the clear write is suppressed there and restarts on the new back bank.
    if (line_start) begin
      state_d = ST_CLEAR;
      clr_x_d = '0;
    end else if (state_q == ST_CLEAR) begin
      ram_we = 1'b1;
      ram_wa = {~front_q, clr_x_q};
      ram_wd = bg_rgb;
      if (clr_x_q == C_LAST_X) begin
        state_d = ST_IDLE;
        clr_x_d = '0;
      end else begin
        clr_x_d = clr_x_q + XW'(1);
      end
    end
`endif
  end

  // Read side: stage 1 is the registered RAM read, stage 2 the scaler.
  always_comb begin
    rd_vld_d   = pix_en;
    rd_black_d = rd_black_q;
    ram_ra     = {front_q, x};
    if (pix_en) begin
      rd_black_d = (x >= C_W_X);
    end
    // Keep the RAM index in range; the black flag overrides the data.
    if (x >= C_W_X) begin
      ram_ra = {front_q, {XW{1'b0}}};
    end

    rgb_d = rgb_q;
    if (rd_vld_q) begin
      rgb_d = rd_black_q ? 24'h0 : scale_rgb(ram_rd, brightness);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_black_q <= 1'b0;
      rgb_q      <= 24'h0;
    end else begin
      front_q    <= front_d;
      wr_err_q   <= wr_err_d;
      rd_vld_q   <= rd_vld_d;
      rd_black_q <= rd_black_d;
      rgb_q      <= rgb_d;
    end
  end

`ifdef SCANLINE_CLEAR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      clr_x_q <= '0;
    end else begin
      state_q <= state_d;
      clr_x_q <= clr_x_d;
    end
  end
`endif

  line_ram #(
    .WIDTH (WIDTH),
    .XW    (XW)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_wa),
    .wr_data (ram_wd),
    .rd_en   (pix_en),
    .rd_addr (ram_ra),
    .rd_data (ram_rd)
  );

  assign R      = rgb_q[23:16];
  assign G      = rgb_q[15:8];
  assign B      = rgb_q[7:0];
  assign wr_err = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_scanline_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_scanline_buffer
// Purpose : Self-checking bench for scanline_buffer. A bank-level model of
//           the two scanlines is compared against R/G/B, wr_ready and wr_err
//           on every falling edge; directed steps add literal expectations.
//           Honours SCANLINE_CLEAR_EN the same way the design does.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scanline_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        line_start = 1'b0;
  logic        vlookahead = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  x = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [9:0]  wr_x = '0;
  logic [23:0] wr_rgb = '0;
  logic [23:0] bg_rgb = 24'h0000FF;
  logic [7:0]  brightness = 8'hFF;
  logic [7:0]  R, G, B;
  logic        wr_err;

  int n_tests = 0;
  int n_fail  = 0;

  scanline_buffer #(.WIDTH(640), .XW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .vlookahead (vlookahead),
    .pix_en     (pix_en),
    .x          (x),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_rgb     (wr_rgb),
    .bg_rgb     (bg_rgb),
    .brightness (brightness),
    .R          (R),
    .G          (G),
    .B          (B),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [23:0] m_bank  [2][640];
  bit          m_known [2][640];
  bit          m_front;
  bit          m_err;
  logic [23:0] m_out;
  bit          m_out_known;
  bit          m_p1_valid, m_p1_black, m_p1_known;
  logic [23:0] m_p1_val;
  int          m_clr_left;

  function automatic logic [23:0] scale_px(input logic [23:0] p,
                                           input logic [7:0] b);
    int r, g, bl;
    if (b == 8'd255) return p;
    r  = int'(p[23:16]) * int'(b) / 256;
    g  = int'(p[15:8])  * int'(b) / 256;
    bl = int'(p[7:0])   * int'(b) / 256;
    return {8'(r), 8'(g), 8'(bl)};
  endfunction

  function automatic bit exp_ready();
    return vlookahead && (m_clr_left == 0);
  endfunction

  task automatic model_reset();
    m_front     = 1'b0;
    m_err       = 1'b0;
    m_out       = 24'h0;
    m_out_known = 1'b1;
    m_p1_valid  = 1'b0;
    m_clr_left  = 0;
  endtask

  // Applies one rising edge with the inputs currently on the pins.
  task automatic model_step();
    int idx;
    if (m_p1_valid) begin
      m_out_known = m_p1_black || m_p1_known;
      m_out       = m_p1_black ? 24'h0 : scale_px(m_p1_val, brightness);
    end
    m_p1_valid = pix_en;
    if (pix_en) begin
      m_p1_black = (int'(x) >= 640);
      if (int'(x) < 640) begin
        m_p1_val   = m_bank[m_front][x];
        m_p1_known = m_known[m_front][x];
      end else begin
        m_p1_val   = 24'h0;
        m_p1_known = 1'b1;
      end
    end
    if (wr_valid && exp_ready()) begin
      if (int'(wr_x) < 640) begin
        m_bank[!m_front][wr_x]  = wr_rgb;
        m_known[!m_front][wr_x] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
`ifdef SCANLINE_CLEAR_EN
    if (m_clr_left > 0 && !line_start) begin
      idx = 640 - m_clr_left;
      m_bank[!m_front][idx]  = bg_rgb;
      m_known[!m_front][idx] = 1'b1;
      m_clr_left--;
    end
    if (line_start) m_clr_left = 640;
`endif
    if (line_start) m_front = !m_front;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 640; i++) m_known[b][i] = 1'b0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_reset();
      end else begin
        if (m_out_known) chk("stream_rgb", {8'h0, R, G, B}, {8'h0, m_out});
        chk("stream_wr_ready", {31'h0, wr_ready}, {31'h0, exp_ready()});
        chk("stream_wr_err", {31'h0, wr_err}, {31'h0, m_err});
        model_step();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_px(input int xx);
    pix_en = 1'b1;
    x      = 10'(xx);
    tick();
    pix_en = 1'b0;
    tick();
  endtask

  task automatic wr_px(input int xx, input logic [23:0] c, input bit ls);
    int n;
    n = 0;
    while (!wr_ready && n < 3000) begin
      tick();
      n++;
    end
    chk("wr_ready_wait", {31'h0, wr_ready}, 32'h1);
    wr_valid   = 1'b1;
    wr_x       = 10'(xx);
    wr_rgb     = c;
    line_start = ls;
    tick();
    wr_valid   = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic swap();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic sweep(input int lx0, input logic [23:0] lv0,
                       input int lx1, input logic [23:0] lv1);
    for (int i = 0; i < 640; i++) begin
      rd_px(i);
      if (i == lx0) chk("sweep_lit0", {8'h0, R, G, B}, {8'h0, lv0});
      if (i == lx1) chk("sweep_lit1", {8'h0, R, G, B}, {8'h0, lv1});
    end
  endtask

  initial begin
    int cnt;
    // Reset state
    tick();
    tick();
    chk("rst_rgb", {8'h0, R, G, B}, 32'h0);
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
    chk("rst_wr_err", {31'h0, wr_err}, 32'h0);
    rst        = 1'b1;
    vlookahead = 1'b1;
    tick();
    chk("ready_after_rst", {31'h0, wr_ready}, 32'h1);

    // Basic write, swap, read at unity and half brightness
    wr_px(5, 24'hFF8040, 1'b0);
    swap();
    brightness = 8'd255;
    rd_px(5);
    chk("px5_unity", {8'h0, R, G, B}, 32'h00FF8040);
    brightness = 8'd128;
    rd_px(5);
    chk("px5_half", {8'h0, R, G, B}, 32'h007F4020);
    brightness = 8'd255;

    // Writes are refused while vlookahead is low
    vlookahead = 1'b0;
    wr_valid   = 1'b1;
    wr_x       = 10'd7;
    wr_rgb     = 24'h123456;
    tick();
    chk("ready_no_lookahead", {31'h0, wr_ready}, 32'h0);
    wr_valid   = 1'b0;
    vlookahead = 1'b1;

    // Out-of-range write and read
    wr_px(700, 24'hABCDEF, 1'b0);
    chk("err_set", {31'h0, wr_err}, 32'h1);
    rd_px(700);
    chk("x_oob_black", {8'h0, R, G, B}, 32'h0);
    rd_px(5);
    chk("px5_untouched", {8'h0, R, G, B}, 32'h00FF8040);

    // Write in the same clk as line_start lands on the line now displayed
    wr_px(10, 24'h0A0B0C, 1'b1);
`ifdef SCANLINE_CLEAR_EN
    cnt = 0;
    while (!wr_ready && cnt < 2000) begin
      cnt++;
      tick();
    end
    chk("clear_busy_len", 32'(cnt), 32'd640);
`else
    chk("ready_after_swap", {31'h0, wr_ready}, 32'h1);
`endif
    rd_px(10);
    chk("same_clk_write", {8'h0, R, G, B}, 32'h000A0B0C);

    // Full sweep of the displayed bank
`ifdef SCANLINE_CLEAR_EN
    sweep(0, 24'h0000FF, 10, 24'h0A0B0C);
`else
    sweep(10, 24'h0A0B0C, 10, 24'h0A0B0C);
`endif

    // Next line: one new pixel, the rest is cleared or stale
    wr_px(3, 24'h102030, 1'b0);
    swap();
`ifdef SCANLINE_CLEAR_EN
    sweep(3, 24'h102030, 5, 24'h0000FF);
`else
    sweep(3, 24'h102030, 5, 24'hFF8040);
`endif
    chk("err_sticky", {31'h0, wr_err}, 32'h1);

    // Asynchronous reset in the middle of a line
    rd_px(3);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_rgb", {8'h0, R, G, B}, 32'h0);
    chk("async_rst_ready", {31'h0, wr_ready}, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("err_cleared", {31'h0, wr_err}, 32'h0);
    // Bank select back at 0: this write must go to the bank shown next line
    wr_px(20, 24'h112233, 1'b0);
    swap();
    rd_px(20);
    chk("front_after_rst", {8'h0, R, G, B}, 32'h00112233);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/scanline_buffer.md
# scanline_buffer

Double-buffered 640-pixel scanline store between the GPU pixel renderer and the `vga` timing controller. During each line the renderer fills the back bank while the front bank is streamed out on `R`/`G`/`B`, one pixel per VGA pixel enable, with brightness scaling applied. Banks swap on every `line_start` pulse from `vga`, so rendering always runs exactly one line ahead of the beam.

## Interface
- `WIDTH`, 640, pixels per line (bank depth)
- `XW`, 10, width of x coordinates

- `clk` in 1: system clock (50 MHz)
- `rst` in 1: asynchronous, active-low reset
- `line_start` in 1: one-clk pulse from `vga` at the start of each line
- `vlookahead` in 1: high while the line being rendered will be visible; gates writes
- `pix_en` in 1: VGA pixel enable (`vga_clk_enable`), one clk in two
- `x` in XW: current beam x from `vga`
- `wr_valid` in 1: renderer write request
- `wr_ready` out 1: buffer can accept a write this cycle
- `wr_x` in XW: write column
- `wr_rgb` in 24: pixel `{R,G,B}`
- `bg_rgb` in 24: background colour used by clear
- `brightness` in 8: global brightness, 255 = unity
- `R`, `G`, `B` out 8 each: scaled pixel colour
- `wr_err` out 1: sticky; a write had `wr_x >= WIDTH`

## Operation
- Two banks. `front` selects the read bank; the write bank is `~front`. `front` toggles on each `line_start`.
- A write is accepted when `wr_valid && wr_ready`. It stores `wr_rgb` at `wr_x` in the write bank.
- If `wr_x >= WIDTH`, the write is accepted and dropped, and `wr_err` is set. `wr_err` clears only on reset.
- Read side: on a `pix_en` cycle, the front bank is read at `x`. If `x >= WIDTH`, the read is treated as black (0).
- Scaling is per channel: `c_out = (brightness == 255) ? c : (c * brightness) >> 8`. It uses an 8x8 multiply and takes bits [15:8], so there is no overflow.
- `R`/`G`/`B` hold their value between `pix_en` updates.
- Clear FSM (present only with the macro below):
  - States are IDLE and CLEAR.
  - On `line_start`: go to CLEAR with `clr_x = 0`.
  - In CLEAR, each clk writes `bg_rgb` to the new write bank at `clr_x` and increments `clr_x`.
  - Return to IDLE after `clr_x == WIDTH-1`, i.e. 640 clks.
  - `line_start` during CLEAR restarts the clear at 0 on the newly swapped bank.
- `wr_ready = vlookahead && (state == IDLE)`.

## Timing
- Reset values:
  - `front = 0`, state IDLE, `clr_x = 0`
  - `R = G = B = 0`
  - `wr_err = 0`, `wr_ready = 0`
- Write: single cycle; the data is readable from that bank after the next swap.
- Read latency: `x` sampled on a `pix_en` clk; `R`/`G`/`B` update 2 clks later (registered RAM read, then registered scale).
- Swap takes effect the clk after `line_start`. A write accepted in the same clk as `line_start` lands in the old write bank, which becomes front.
- Pixels already in the read pipeline when the swap happens complete from the old bank.
- Line period is 1600 clks. Clear (640 clks) plus a full 640-pixel render at one write per clk fits within the line.
- Reset mid-line: all state returns to reset values immediately. RAM contents are not cleared.

## Configuration
- `SCANLINE_CLEAR_EN` defined:
  - The clear FSM is built.
  - The back bank is filled with `bg_rgb` after every swap.
  - `wr_ready` is low for 640 clks after each `line_start`.
- Not defined:
  - No clear FSM.
  - `wr_ready = vlookahead`.
  - Unwritten pixels keep data from two lines earlier; the renderer owns full coverage.

## Structure
- Shared package `gpu_pkg` holds:
  - `SCREEN_W = 640`, `SCREEN_H = 480`
  - `typedef logic [23:0] rgb_t`
  - `typedef logic [9:0] coord_t`
- Sub-module `line_ram`: simple dual-port memory, 2×WIDTH×24 bits.
  - Write port: bank bit concatenated with column.
  - Read port: registered output.
  - Instantiated once.
- The top-level block holds bank select, clear FSM, write arbitration and the scaling pipeline.

## Test plan
- Reset, then write `wr_x = 5`, `wr_rgb = FF8040`, pulse `line_start`, drive `pix_en` with `x = 5`, `brightness = 255` → 2 clks later `R/G/B = FF/80/40`.
- Same pixel with `brightness = 128` → `R/G/B = 7F/40/20`.
- Write `wr_x = 700` → no RAM change, `wr_err = 1` and stays 1 until `rst` low.
- With `SCANLINE_CLEAR_EN`, `bg_rgb = 0000FF`:
  - After `line_start`, `wr_ready = 0` for exactly 640 clks.
  - After the next swap, every x in 0..639 reads `0000FF` except the written pixels.
- Write on the same clk as `line_start` at `wr_x = 10` → the pixel appears on the line now being displayed, not the next one.
- Assert `rst` low mid-line → `R/G/B = 0`, `wr_ready = 0` and `front = 0` in the same cycle, independent of `clk`.
